load_store_unit: RTL and testbench

// Initiator side of the data-memory interface: sits between the execute stage and data_memory.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store initiator; optional LSU_MISALIGNED_SPLIT_EN byte-splits misaligned ops
module load_store_unit #(
  parameter int DMEM_DATA_WIDTH = 32,
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
  output logic                       resp_valid,
  output logic [DMEM_DATA_WIDTH-1:0] resp_rdata,
  output logic                       resp_err,
  output logic                       mem_wr_en,
  output logic [1:0]                 mem_rw_mode,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] mem_w_data,
  input  logic [DMEM_DATA_WIDTH-1:0] mem_r_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_WORD = 2'd2;

  logic [1:0] state;
  logic       we_q;
  logic [2:0] f3_q;
  logic       err_q;   // misaligned op with splitting off: dummy ACCESS cycle, then error

  logic       req_legal;
  logic       req_aligned;
  logic [1:0] req_mode;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic [31:0] wdata_q;
  logic [31:0] acc_q;
  logic [31:0] acc_next;
  logic [1:0]  nidx;
  logic [7:0]  next_wbyte;
`endif

  assign req_ready = (state == ST_IDLE);

  // Apply load extension rules to raw little-endian data
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'd0, d[7:0]};
      3'b101:  extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Decode legality, natural access size and alignment of the incoming request
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_mode = MODE_BYTE;
      2'b01:   req_mode = MODE_HALF;
      default: req_mode = MODE_WORD;
    endcase
    if (req_we)
      req_legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    else
      req_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    case (req_funct3[1:0])
      2'b00:   req_aligned = 1'b1;
      2'b01:   req_aligned = !req_addr[0];
      default: req_aligned = (req_addr[1:0] == 2'b00);
    endcase
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  // Merge the current byte into the load accumulator and pick the next store byte
  always_comb begin
    acc_next = acc_q;
    case (idx_q)
      2'd0:    acc_next[7:0]   = mem_r_data[7:0];
      2'd1:    acc_next[15:8]  = mem_r_data[7:0];
      2'd2:    acc_next[23:16] = mem_r_data[7:0];
      default: acc_next[31:24] = mem_r_data[7:0];
    endcase
    nidx = idx_q + 2'd1;
    case (nidx)
      2'd0:    next_wbyte = wdata_q[7:0];
      2'd1:    next_wbyte = wdata_q[15:8];
      2'd2:    next_wbyte = wdata_q[23:16];
      default: next_wbyte = wdata_q[31:24];
    endcase
  end
`endif

  // Request FSM: accept, drive memory for one or more ACCESS cycles, pulse response
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rw_mode <= MODE_BYTE;
      mem_addr    <= '0;
      mem_w_data  <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      err_q       <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q     <= 1'b0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      wdata_q     <= '0;
      acc_q       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            err_q <= 1'b0;
            if (!req_legal) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_aligned) begin
              state       <= ST_ACCESS;
              mem_addr    <= req_addr;
              mem_rw_mode <= req_mode;
              mem_w_data  <= req_wdata;
              mem_wr_en   <= req_we;
`ifdef LSU_MISALIGNED_SPLIT_EN
              split_q     <= 1'b0;
`endif
            end else begin
              state <= ST_ACCESS;
`ifdef LSU_MISALIGNED_SPLIT_EN
              split_q     <= 1'b1;
              idx_q       <= 2'd0;
              last_q      <= (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
              wdata_q     <= req_wdata;
              acc_q       <= '0;
              mem_addr    <= req_addr;
              mem_rw_mode <= MODE_BYTE;
              mem_w_data  <= {24'd0, req_wdata[7:0]};
              mem_wr_en   <= req_we;
`else
              err_q <= 1'b1;
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (err_q) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
          end else if (split_q && (idx_q != last_q)) begin
            idx_q      <= nidx;
            acc_q      <= acc_next;
            mem_addr   <= mem_addr + {{(DMEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
            mem_w_data <= {24'd0, next_wbyte};
          end else if (split_q) begin
            mem_wr_en  <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : extend(f3_q, acc_next);
`endif
          end else begin
            mem_wr_en  <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : extend(f3_q, mem_r_data);
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with data-memory and reference models
module tb_load_store_unit;

  localparam int AW = 12;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_wr_en;
  logic [1:0]    mem_rw_mode;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_w_data;
  logic [31:0]   mem_r_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DMEM_DATA_WIDTH(32), .DMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  // Data memory model: little-endian bytes, combinational read, write on clock
  logic [7:0]    dmem    [0:4095];
  logic [7:0]    ref_mem [0:4095];
  int            wr_cycles = 0;
  logic [1:0]    last_wr_mode;
  logic [AW-1:0] ma1, ma2, ma3;
  assign ma1 = mem_addr + 12'd1;
  assign ma2 = mem_addr + 12'd2;
  assign ma3 = mem_addr + 12'd3;

  always_comb begin
    mem_r_data = {24'd0, dmem[mem_addr]};
    if (mem_rw_mode == 2'd1)
      mem_r_data = {16'd0, dmem[ma1], dmem[mem_addr]};
    else if (mem_rw_mode == 2'd2)
      mem_r_data = {dmem[ma3], dmem[ma2], dmem[ma1], dmem[mem_addr]};
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_cycles = wr_cycles + 1;
      last_wr_mode = mem_rw_mode;
      dmem[mem_addr] = mem_w_data[7:0];
      if (mem_rw_mode != 2'd0) dmem[ma1] = mem_w_data[15:8];
      if (mem_rw_mode == 2'd2) begin
        dmem[ma2] = mem_w_data[23:16];
        dmem[ma3] = mem_w_data[31:24];
      end
    end
  end

  function automatic bit is_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = dmem[AW'(a + k)];
    return w;
  endfunction

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[AW'(a + k)];
    return w;
  endfunction

  // One request end to end; expectations come from the reference rules
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input string name, output logic [31:0] rd);
    int sz, exp_lat, exp_writes, lat, w0;
    bit lg, al, acc_ok;
    logic exp_err;
    logic [31:0] exp_rd, raw;
    lg = is_legal(we, f3);
    sz = op_size(f3);
    al = (addr % sz) == 0;
    acc_ok = lg && (al || SPLIT);
    exp_err = !acc_ok;
    exp_lat = !lg ? 1 : ((al || !SPLIT) ? 2 : sz + 1);
    exp_writes = (acc_ok && we) ? (al ? 1 : sz) : 0;
    exp_rd = 32'd0;
    if (acc_ok && we)
      for (int k = 0; k < sz; k++) ref_mem[AW'(addr + k)] = wdata[8*k +: 8];
    if (acc_ok && !we) begin
      raw = 32'd0;
      for (int k = 0; k < sz; k++) raw[8*k +: 8] = ref_mem[AW'(addr + k)];
      case (f3)
        3'd0: exp_rd = (raw[7] ? 32'hFFFFFF00 : 32'd0) | raw;
        3'd1: exp_rd = (raw[15] ? 32'hFFFF0000 : 32'd0) | raw;
        default: exp_rd = raw;
      endcase
    end

    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before got %b exp 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    w0 = wr_cycles;
    @(posedge clk); #1;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    rd = resp_rdata;
    n_checks++;
    if (lat != exp_lat || resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (resp_err !== exp_err) begin
      n_fail++; $display("FAIL %s resp_err got %b exp %b", name, resp_err, exp_err);
    end
    n_checks++;
    if (resp_rdata !== exp_rd) begin
      n_fail++; $display("FAIL %s resp_rdata got %h exp %h", name, resp_rdata, exp_rd);
    end
    n_checks++;
    if (wr_cycles - w0 != exp_writes) begin
      n_fail++; $display("FAIL %s write_cycles got %0d exp %0d", name, wr_cycles - w0, exp_writes);
    end
    if (exp_writes == 1) begin
      n_checks++;
      if (last_wr_mode !== f3[1:0]) begin
        n_fail++; $display("FAIL %s write_mode got %0d exp %0d", name, last_wr_mode, f3[1:0]);
      end
    end
    if (we) begin
      n_checks++;
      if (mem_word(addr) !== ref_word(addr)) begin
        n_fail++; $display("FAIL %s mem_bytes got %h exp %h", name, mem_word(addr), ref_word(addr));
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp_rd || resp_err !== exp_err) begin
      n_fail++; $display("FAIL %s after_resp got valid=%b ready=%b rdata=%h err=%b exp 0 1 %h %b",
                         name, resp_valid, req_ready, resp_rdata, resp_err, exp_rd, exp_err);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
        mem_wr_en !== 1'b0 || mem_addr !== 12'd0 || mem_w_data !== 32'd0 || mem_rw_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL %s got ready=%b v=%b rd=%h err=%b we=%b a=%h wd=%h mode=%0d exp 1 0 0 0 0 0 0 0",
               name, req_ready, resp_valid, resp_rdata, resp_err, mem_wr_en, mem_addr, mem_w_data, mem_rw_mode);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd;
    run_op(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, "sw_010", rd);
    run_op(1'b0, 3'b010, 12'h010, 32'h0, "lw_010", rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_const got %h exp deadbeef", rd); end
  endtask

  task automatic test_byte();
    logic [31:0] rd;
    run_op(1'b1, 3'b000, 12'h021, 32'h12345680, "sb_021", rd);
    run_op(1'b0, 3'b000, 12'h021, 32'h0, "lb_021", rd);
    n_checks++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_const got %h exp ffffff80", rd); end
    run_op(1'b0, 3'b100, 12'h021, 32'h0, "lbu_021", rd);
    n_checks++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_const got %h exp 00000080", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd;
    run_op(1'b1, 3'b001, 12'h032, 32'hABCD8001, "sh_032", rd);
    run_op(1'b0, 3'b001, 12'h032, 32'h0, "lh_032", rd);
    n_checks++;
    if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_const got %h exp ffff8001", rd); end
    run_op(1'b0, 3'b101, 12'h032, 32'h0, "lhu_032", rd);
    n_checks++;
    if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu_const got %h exp 00008001", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    run_op(1'b1, 3'b010, 12'hFFE, 32'h11223344, "sw_ffe", rd);
    run_op(1'b0, 3'b010, 12'hFFE, 32'h0, "lw_ffe", rd);
    if (SPLIT) begin
      n_checks++;
      if (rd !== 32'h11223344 || dmem[12'hFFE] !== 8'h44 || dmem[12'hFFF] !== 8'h33 ||
          dmem[12'h000] !== 8'h22 || dmem[12'h001] !== 8'h11) begin
        n_fail++; $display("FAIL split_wrap got %h exp 11223344", rd);
      end
    end
    run_op(1'b0, 3'b001, 12'h003, 32'h0, "lh_003", rd);
    run_op(1'b1, 3'b001, 12'h045, 32'h0000A55A, "sh_045", rd);
    run_op(1'b0, 3'b101, 12'h045, 32'h0, "lhu_045", rd);
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    run_op(1'b0, 3'b011, 12'h010, 32'h0, "ld_f3_011", rd);
    run_op(1'b0, 3'b110, 12'h011, 32'h0, "ld_f3_110", rd);
    run_op(1'b0, 3'b111, 12'h012, 32'h0, "ld_f3_111", rd);
    run_op(1'b1, 3'b011, 12'h010, 32'hFFFFFFFF, "st_f3_011", rd);
    run_op(1'b1, 3'b100, 12'h010, 32'hFFFFFFFF, "st_f3_100", rd);
    run_op(1'b1, 3'b110, 12'h010, 32'hFFFFFFFF, "st_f3_110", rd);
  endtask

  task automatic test_reset_mid();
    logic [7:0] old2, old3;
    old2 = dmem[12'h063]; old3 = dmem[12'h064];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = SPLIT ? 12'h061 : 12'h060;
    req_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (SPLIT) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || mem_wr_en !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got ready=%b wr_en=%b valid=%b exp 1 0 0", req_ready, mem_wr_en, resp_valid);
    end
    check_reset_values("rst_mid_values");
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resp got %b exp 0", resp_valid); end
    end
    if (SPLIT) begin
      n_checks++;
      if (dmem[12'h061] !== 8'hD4 || dmem[12'h062] !== 8'hC3 || dmem[12'h063] !== old2 || dmem[12'h064] !== old3) begin
        n_fail++; $display("FAIL rst_mid_bytes got %h %h %h %h exp d4 c3 %h %h",
                           dmem[12'h061], dmem[12'h062], dmem[12'h063], dmem[12'h064], old2, old3);
      end
      ref_mem[12'h061] = 8'hD4; ref_mem[12'h062] = 8'hC3;
    end else begin
      for (int k = 0; k < 4; k++) ref_mem[12'h060 + k] = dmem[12'h060 + k];
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [AW-1:0] a;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'(12'hFFC + $urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      run_op(1'($urandom), 3'($urandom), a, $urandom, "random", rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
